// File: rtl/neuron_pkg.sv
// neuron_pkg
// Shared definitions for the neuron summation path.
//   M_DEF, N_DEF, INTBITS_DEF, FRACBITS_DEF : default frame geometry / number format
//   N_MAX                                   : widest word sm_normalize can handle
//   state_t                                 : operand collector FSM states
//   sm_normalize()                          : rewrites sign-magnitude negative zero as +0
package neuron_pkg;

  localparam int M_DEF        = 8;
  localparam int N_DEF        = 32;
  localparam int INTBITS_DEF  = 12;
  localparam int FRACBITS_DEF = 20;
  localparam int N_MAX        = 64;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // word holds a width-bit sign-magnitude value in its low bits (upper bits zero).
  // A set sign bit with an all-zero magnitude collapses to +0.
  function automatic logic [N_MAX-1:0] sm_normalize(input logic [N_MAX-1:0] word,
                                                    input int width);
    logic sign;
    logic mag_nz;
    sign   = 1'b0;
    mag_nz = 1'b0;
    for (int i = 0; i < N_MAX; i++) begin
      if (i < width - 1) mag_nz = mag_nz | word[i];
      if (i == width - 1) sign = word[i];
    end
    if (sign && !mag_nz) return '0;
    return word;
  endfunction

endpackage

// File: rtl/tc2sm_conv.sv
// tc2sm_conv
// Combinational n-bit two's-complement to sign-magnitude converter.
// Used by operand_collector only when OPERAND_COLLECTOR_TC2SM_EN is defined.
//   tc_word : two's-complement input
//   sm_word : sign-magnitude output; the most negative input saturates to
//             sign=1 with an all-ones magnitude, zero maps to +0
module tc2sm_conv #(
  parameter int n = 32
) (
  input  logic [n-1:0] tc_word,
  output logic [n-1:0] sm_word
);

  localparam int MW = n - 1;

  logic [MW-1:0] neg_mag;

  // Magnitude of a negative value: low bits of the two's-complement negation.
  assign neg_mag = ~tc_word[MW-1:0] + MW'(1);

  always_comb begin
    sm_word = tc_word;
    if (tc_word[n-1]) begin
      if (tc_word[MW-1:0] == '0) sm_word = '1;  // -2^(n-1) has no magnitude; saturate
      else                       sm_word = {1'b1, neg_mag};
    end
  end

endmodule

// File: rtl/operand_collector.sv
// operand_collector
// Packs a stream of n-bit sign-magnitude words into an m-slot frame for the
// neuron adder tree and holds the frame until the consumer takes it.
// Optional build macro: OPERAND_COLLECTOR_TC2SM_EN -- input words are two's
// complement and get converted to sign-magnitude on the write path.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : input word handshake; in_data word, in_last ends frame early
//   out_valid/out_ready : frame handshake
//   operand             : packed frame, slot k at operand[n*(k+1)-1 -: n]
//   out_count           : number of slots filled by real words
module operand_collector
  import neuron_pkg::*;
#(
  parameter int m        = M_DEF,
  parameter int n        = N_DEF,
  parameter int intbits  = INTBITS_DEF,
  parameter int fracbits = FRACBITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [n-1:0]           in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [n*m-1:0]         operand,
  output logic [$clog2(m+1)-1:0] out_count
);

  localparam int CW  = $clog2(m);
  localparam int OCW = $clog2(m+1);

  state_t         state_reg, state_next;
  logic [CW-1:0]  count_reg;
  logic [OCW-1:0] out_count_reg;
  logic [n-1:0]   slot_reg [m];

  logic [n-1:0]   conv_data;
  logic [n-1:0]   wdata;
  logic           accept;
  logic           frame_done;

`ifdef OPERAND_COLLECTOR_TC2SM_EN
  tc2sm_conv #(.n(n)) u_tc2sm_conv (
    .tc_word (in_data),
    .sm_word (conv_data)
  );
`else
  assign conv_data = in_data;
`endif

  assign wdata      = n'(sm_normalize(N_MAX'(conv_data), n));
  assign accept     = in_valid & in_ready;
  // The slot counter never passes m-1: the frame closes on that slot at the latest.
  assign frame_done = accept & (in_last | (count_reg == CW'(m - 1)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= FILL;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FILL: if (frame_done) state_next = HOLD;
      HOLD: if (out_ready)  state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      FILL: in_ready  = 1'b1;
      HOLD: out_valid = 1'b1;
      default: in_ready = 1'b1;
    endcase
  end

  // Slot storage, counter and fill count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < m; k++) slot_reg[k] <= '0;
      count_reg     <= '0;
      out_count_reg <= '0;
    end else if (accept) begin
      for (int k = 0; k < m; k++) begin
        if (count_reg == CW'(k)) slot_reg[k] <= wdata;
      end
      if (frame_done) out_count_reg <= OCW'(count_reg) + OCW'(1);
      else            count_reg     <= count_reg + CW'(1);
    end else if (out_valid && out_ready) begin
      // Frame consumed: start the next one from a clean, zeroed frame.
      for (int k = 0; k < m; k++) slot_reg[k] <= '0;
      count_reg     <= '0;
      out_count_reg <= '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < m; gi++) begin : g_pack
      assign operand[n*(gi+1)-1 -: n] = slot_reg[gi];
    end
  endgenerate

  assign out_count = out_count_reg;

endmodule
